// File: rtl/seg7_mux_reader_pkg.sv
// Segment code table, digit-enable indices and the frame record shared by the display reader.
package seg7_mux_reader_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_6_ALT = 7'h7C;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DIG_UNITS = 0;
    localparam int DIG_TENS  = 1;

    typedef struct packed {
        logic [3:0] tens;
        logic       blank;
        logic [3:0] units;
    } frame_t;

    localparam frame_t FRAME_BLANK = '{tens: 4'd0, blank: 1'b1, units: 4'd0};

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-code to BCD decoder; zero latency, no flow control.
// Blank (all segments off) is reported as legal with blank set; the caller decides where it is allowed.
module seg7_to_bcd
    import seg7_mux_reader_pkg::*;
(
    input  logic [6:0] code,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        bcd   = 4'd0;
        case (code)
            SEG_0:               bcd = 4'd0;
            SEG_1:               bcd = 4'd1;
            SEG_2:               bcd = 4'd2;
            SEG_3:               bcd = 4'd3;
            SEG_4:               bcd = 4'd4;
            SEG_5:               bcd = 4'd5;
            SEG_6, SEG_6_ALT:    bcd = 4'd6;
            SEG_7, SEG_7_ALT:    bcd = 4'd7;
            SEG_8:               bcd = 4'd8;
            SEG_9, SEG_9_ALT:    bcd = 4'd9;
            SEG_BLANK:           blank = 1'b1;
            default:             legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_mux_reader.sv
// Reads a two-digit multiplexed 7-seg bus back to BCD and publishes it after STABLE_FRAMES equal frames.
// Latency: 2 sync + SETTLE + frames + 2 regs; no backpressure, the display bus is free-running.
module seg7_mux_reader
    import seg7_mux_reader_pkg::*;
#(
    parameter int SETTLE        = 2,
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic [1:0] dig_en_in,
    input  logic       seg_inv,
    input  logic       dig_inv,
    output logic [3:0] digit1,
    output logic [3:0] digit10,
    output logic       blank10,
    output logic       valid,
    output logic       update,
    output logic       err_pattern,
    output logic       err_overlap
);

    localparam int PW = $clog2(SETTLE + 1) + 1;
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]    seg_m, seg_q, seg_s;
    logic [1:0]    en_m, en_q, en_a, en_prev;
    logic [1:0]    fill;
    logic [PW-1:0] phase_cnt, cur_cnt, phase_nxt;
    logic          one_hot, overlap, do_sample, samp_units, samp_tens;
    logic          dec_legal, dec_blank;
    logic [3:0]    dec_bcd;
    logic          bad_code, close_ok, timeout_hit, pub_req;
    logic          tens_seen, tens_blank, frame_bad;
    logic [3:0]    tens_val;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] to_cnt;
    frame_t        cand, pub, new_frame;

    // Sync flops come out of reset at zero, which reads as "all enabled" when dig_inv=1;
    // enables are masked until the synchronizer has been refilled with real bus values.
    assign seg_s = seg_q ^ {7{seg_inv}};
    assign en_a  = fill[1] ? (en_q ^ {2{dig_inv}}) : 2'b00;

    seg7_to_bcd u_dec (
        .code  (seg_s),
        .legal (dec_legal),
        .blank (dec_blank),
        .bcd   (dec_bcd)
    );

    always_comb begin
        one_hot    = ^en_a;
        overlap    = &en_a;
        cur_cnt    = (one_hot && en_a == en_prev) ? phase_cnt : '0;
        do_sample  = one_hot && (cur_cnt == PW'(SETTLE - 1));
        samp_units = do_sample && en_a[DIG_UNITS];
        samp_tens  = do_sample && en_a[DIG_TENS];
        phase_nxt  = '0;
        if (one_hot)
            phase_nxt = (cur_cnt == PW'(SETTLE)) ? cur_cnt : cur_cnt + PW'(1);

        // Blank is a legal tens code but never a legal units code.
        bad_code = (samp_units && (!dec_legal || dec_blank)) || (samp_tens && !dec_legal);
        close_ok = samp_units && dec_legal && !dec_blank && !frame_bad;

        new_frame.units = dec_bcd;
        new_frame.tens  = tens_seen ? tens_val : 4'd0;
        new_frame.blank = !tens_seen || tens_blank;

        timeout_hit = !samp_units && (to_cnt == TW'(TIMEOUT - 1));
        pub_req     = (stab_cnt == SW'(STABLE_FRAMES)) && (!valid || cand != pub);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m       <= '0;
            seg_q       <= '0;
            en_m        <= '0;
            en_q        <= '0;
            fill        <= '0;
            en_prev     <= '0;
            phase_cnt   <= '0;
            err_pattern <= 1'b0;
            err_overlap <= 1'b0;
            tens_seen   <= 1'b0;
            tens_blank  <= 1'b0;
            tens_val    <= '0;
            frame_bad   <= 1'b0;
            to_cnt      <= '0;
            stab_cnt    <= '0;
            cand        <= FRAME_BLANK;
            pub         <= FRAME_BLANK;
            valid       <= 1'b0;
            update      <= 1'b0;
        end else begin
            seg_m       <= seg_in;
            seg_q       <= seg_m;
            en_m        <= dig_en_in;
            en_q        <= en_m;
            fill        <= {fill[0], 1'b1};
            en_prev     <= en_a;
            phase_cnt   <= phase_nxt;
            err_pattern <= bad_code;
            err_overlap <= overlap;

            // Frame assembly: a tens sample waits for the next units sample to close the frame.
            if (overlap) begin
                frame_bad <= 1'b1;
                tens_seen <= 1'b0;
            end else if (samp_tens) begin
                if (!dec_legal) begin
                    frame_bad <= 1'b1;
                end else begin
                    tens_seen  <= 1'b1;
                    tens_val   <= dec_bcd;
                    tens_blank <= dec_blank;
                end
            end else if (samp_units) begin
                tens_seen <= 1'b0;
                frame_bad <= 1'b0;
            end

            if (samp_units)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT))
                to_cnt <= to_cnt + TW'(1);

            if (timeout_hit || bad_code) begin
                stab_cnt <= '0;
            end else if (close_ok) begin
                if (new_frame == cand) begin
                    if (stab_cnt != SW'(STABLE_FRAMES))
                        stab_cnt <= stab_cnt + SW'(1);
                end else begin
                    cand     <= new_frame;
                    stab_cnt <= SW'(1);
                end
            end

            update <= pub_req && !timeout_hit;
            if (timeout_hit) begin
                valid <= 1'b0;
            end else if (pub_req) begin
                valid <= 1'b1;
                pub   <= cand;
            end
        end
    end

    assign digit1  = pub.units;
    assign digit10 = pub.tens;
    assign blank10 = pub.blank;

endmodule

// File: tb/tb_seg7_mux_reader.sv
// Directed bench for seg7_mux_reader: expected publishes are queued as stimulus is driven and popped on update.
module tb_seg7_mux_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [1:0] dig_en_in;
    logic       seg_inv, dig_inv;
    logic [3:0] digit1, digit10;
    logic       blank10, valid, update, err_pattern, err_overlap;

    always #5 clk = ~clk;

    seg7_mux_reader dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_en_in   (dig_en_in),
        .seg_inv     (seg_inv),
        .dig_inv     (dig_inv),
        .digit1      (digit1),
        .digit10     (digit10),
        .blank10     (blank10),
        .valid       (valid),
        .update      (update),
        .err_pattern (err_pattern),
        .err_overlap (err_overlap)
    );

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d10;
        logic       b10;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   n_pat = 0;
    int   n_ovl = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d1, input logic [3:0] d10, input logic b10);
        exp_t e;
        e.d1  = d1;
        e.d10 = d10;
        e.b10 = b10;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every update must match the oldest queued expectation.
    always @(negedge clk) begin
        if (err_pattern) n_pat++;
        if (err_overlap) n_ovl++;
        if (!rst && update) begin
            if (exp_q.size() == 0) begin
                check("spurious_update", update, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("upd_digit1", digit1, mon_e.d1);
                check("upd_digit10", digit10, mon_e.d10);
                check("upd_blank10", blank10, mon_e.b10);
                check("upd_valid", valid, 1);
            end
        end
    end

    task automatic hold(input logic [6:0] code, input logic [1:0] en, input int n);
        seg_in    = seg_inv ? ~code : code;
        dig_en_in = dig_inv ? ~en : en;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] t, input logic [6:0] u, input bit tens_on);
        hold(t, tens_on ? 2'b10 : 2'b00, 16);
        hold(u, 2'b01, 16);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_digit1"}, digit1, 0);
        check({tag, "_digit10"}, digit10, 0);
        check({tag, "_blank10"}, blank10, 1);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_update"}, update, 0);
        check({tag, "_err_pattern"}, err_pattern, 0);
        check({tag, "_err_overlap"}, err_overlap, 0);
    endtask

    initial begin
        rst       = 1'b1;
        seg_inv   = 1'b0;
        dig_inv   = 1'b0;
        seg_in    = 7'h00;
        dig_en_in = 2'b00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        hold(7'h00, 2'b00, 6);

        // "42": publish after the third frame, nothing more on repeats.
        frame(7'h66, 7'h5B, 1);
        frame(7'h66, 7'h5B, 1);
        push(4'd2, 4'd4, 1'b0);
        frame(7'h66, 7'h5B, 1);
        frame(7'h66, 7'h5B, 1);
        frame(7'h66, 7'h5B, 1);
        check("t1_pending", exp_q.size(), 0);
        check("t1_valid", valid, 1);
        check("t1_digit10", digit10, 4);

        // Units only (6 via 0x7D), tens never enabled -> blank tens.
        frame(7'h00, 7'h7D, 0);
        frame(7'h00, 7'h7D, 0);
        push(4'd6, 4'd0, 1'b1);
        frame(7'h00, 7'h7D, 0);
        check("t2_pending", exp_q.size(), 0);
        check("t2_blank10", blank10, 1);

        // "17" plain, then again through inverted polarity after a reset.
        frame(7'h06, 7'h07, 1);
        frame(7'h06, 7'h07, 1);
        push(4'd7, 4'd1, 1'b0);
        frame(7'h06, 7'h07, 1);
        check("t3a_pending", exp_q.size(), 0);
        rst     = 1'b1;
        seg_inv = 1'b1;
        dig_inv = 1'b1;
        hold(7'h00, 2'b00, 3);
        check_reset("inv_reset");
        rst = 1'b0;
        hold(7'h00, 2'b00, 6);
        check("inv_no_overlap", n_ovl, 0);
        frame(7'h06, 7'h27, 1);
        frame(7'h06, 7'h27, 1);
        push(4'd7, 4'd1, 1'b0);
        frame(7'h06, 7'h27, 1);
        check("t3b_pending", exp_q.size(), 0);
        check("t3b_digit1", digit1, 7);

        // "20" stream, a bad frame, then "21" whose count is reset by a bad frame.
        frame(7'h5B, 7'h3F, 1);
        frame(7'h5B, 7'h3F, 1);
        push(4'd0, 4'd2, 1'b0);
        frame(7'h5B, 7'h3F, 1);
        frame(7'h5B, 7'h49, 1);
        check("t4_err_pattern", n_pat, 1);
        frame(7'h5B, 7'h06, 1);
        frame(7'h5B, 7'h06, 1);
        frame(7'h5B, 7'h49, 1);
        frame(7'h5B, 7'h06, 1);
        frame(7'h5B, 7'h06, 1);
        check("t4_no_early_pub", digit1, 0);
        push(4'd1, 4'd2, 1'b0);
        frame(7'h5B, 7'h06, 1);
        check("t4_pending", exp_q.size(), 0);
        check("t4_err_total", n_pat, 2);

        // Overlap pulse; glitches shorter than / equal to SETTLE.
        hold(7'h00, 2'b00, 8);
        hold(7'h00, 2'b11, 1);
        hold(7'h00, 2'b00, 8);
        check("t5_overlap", n_ovl, 1);
        hold(7'h49, 2'b01, 1);
        hold(7'h00, 2'b00, 8);
        check("t5_short_glitch", n_pat, 2);
        hold(7'h49, 2'b01, 2);
        hold(7'h00, 2'b00, 8);
        check("t5_settle_glitch", n_pat, 3);
        check("t5_digits_held", {digit10, digit1}, 8'h21);

        // Timeout, digits held, then "05" re-publishes.
        hold(7'h00, 2'b00, 4000);
        check("t6_before_timeout", valid, 1);
        hold(7'h00, 2'b00, 110);
        check("t6_timeout_valid", valid, 0);
        check("t6_held", {blank10, digit10, digit1}, 9'h021);
        frame(7'h3F, 7'h6D, 1);
        frame(7'h3F, 7'h6D, 1);
        push(4'd5, 4'd0, 1'b0);
        frame(7'h3F, 7'h6D, 1);
        check("t6_pending", exp_q.size(), 0);
        check("t6_valid", valid, 1);

        // Reset in the middle of a tens phase.
        hold(7'h5B, 2'b10, 5);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        hold(7'h00, 2'b00, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
